// File: rtl/vdc_pkg.sv
// Shared types and helpers for the VDC video RAM arbiter.
// Grant tags and the 16k/64k address shuffle applied to every RAM access.
package vdc_pkg;

  typedef enum logic [1:0] {
    G_NONE,
    G_REF,
    G_DISP,
    G_CPU
  } grant_t;

  // 16k parts use a 7+1+8 row/column split; the 64k layout passes straight through.
  function automatic logic [15:0] vdc_shuffle_addr(
    input logic [15:0] addr,
    input logic        has64k,
    input logic        ena64k
  );
    if (has64k && ena64k)
      return addr;
    else if (ena64k)
      return {1'b0, addr[14:9], 1'b0, addr[7:0]};
    else
      return {1'b0, addr[13:8], 1'b0, addr[7:0]};
  endfunction

endpackage

// File: rtl/vdc_refresh_ctr.sv
// DRAM refresh burst counter: loads a slot count on refresh_start and steps
// a free-running 8-bit refresh row address once per refresh slot.
module vdc_refresh_ctr #(
  parameter int REF_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             refresh_start,
  input  logic [REF_W-1:0] refresh_cnt,
  output logic             refresh_busy,
  output logic [7:0]       ref_addr
);

  logic [REF_W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      ref_addr <= 8'h00;
    end else if (count == '0) begin
      // A new burst is only accepted once the previous one has fully drained.
      if (refresh_start)
        count <= refresh_cnt;
    end else if (enable) begin
      count    <= count - REF_W'(1);
      ref_addr <= ref_addr + 8'd1;
    end
  end

  assign refresh_busy = (count != '0);

endmodule

// File: rtl/vdc_ram_arbiter.sv
// Single-port VDC video RAM scheduler: refresh > display > CPU, with a
// starvation guard for the CPU port and a one-slot read-return pipeline.
module vdc_ram_arbiter
  import vdc_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int REF_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ram64k,
  input  logic             reg_ram,
  input  logic             refresh_start,
  input  logic [REF_W-1:0] refresh_cnt,
  output logic             refresh_busy,
  input  logic             disp_req,
  input  logic [15:0]      disp_addr,
  output logic             disp_ack,
  output logic [7:0]       disp_data,
  output logic             disp_valid,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_di,
  output logic             cpu_ack,
  output logic [7:0]       cpu_do,
  output logic             cpu_valid,
  output logic [15:0]      ram_addr,
  output logic             ram_we,
  output logic [7:0]       ram_di,
  input  logic [7:0]       ram_do
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  grant_t      grant;
  grant_t      rd_tag;
  logic [7:0]  starve;
  logic [7:0]  ref_addr;
  logic [15:0] sel_addr;
  logic [15:0] shuf_addr;

  vdc_refresh_ctr #(.REF_W(REF_W)) u_refresh (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .refresh_start (refresh_start),
    .refresh_cnt   (refresh_cnt),
    .refresh_busy  (refresh_busy),
    .ref_addr      (ref_addr)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant    = G_NONE;
    sel_addr = ram_addr;
    if (refresh_busy)
      grant = G_REF;
    else if (cpu_req && starve == STARVE_LIM)
      grant = G_CPU;
    else if (disp_req)
      grant = G_DISP;
    else if (cpu_req)
      grant = G_CPU;

    case (grant)
      G_REF:   sel_addr = {8'h00, ref_addr};
      G_DISP:  sel_addr = disp_addr;
      G_CPU:   sel_addr = cpu_addr;
      default: sel_addr = ram_addr;
    endcase
  end

  assign shuf_addr = vdc_shuffle_addr(sel_addr, ram64k, reg_ram);

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_ack   <= 1'b0;
      disp_data  <= 8'h00;
      disp_valid <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_do     <= 8'h00;
      cpu_valid  <= 1'b0;
      ram_addr   <= 16'h0000;
      ram_we     <= 1'b0;
      ram_di     <= 8'h00;
      rd_tag     <= G_NONE;
      starve     <= 8'h00;
    end else begin
      disp_ack   <= 1'b0;
      cpu_ack    <= 1'b0;
      disp_valid <= 1'b0;
      cpu_valid  <= 1'b0;
      ram_we     <= 1'b0;

      if (enable) begin
        // Data for the read issued last slot is on ram_do now; return it to its owner.
        case (rd_tag)
          G_DISP: begin
            disp_data  <= ram_do;
            disp_valid <= 1'b1;
          end
          G_CPU: begin
            cpu_do    <= ram_do;
            cpu_valid <= 1'b1;
          end
          default: ;
        endcase
        rd_tag <= G_NONE;

        case (grant)
          G_REF: ram_addr <= shuf_addr;
          G_DISP: begin
            ram_addr <= shuf_addr;
            disp_ack <= 1'b1;
            rd_tag   <= G_DISP;
          end
          G_CPU: begin
            ram_addr <= shuf_addr;
            ram_we   <= cpu_we;
            cpu_ack  <= 1'b1;
            if (cpu_we)
              ram_di <= cpu_di;
            else
              rd_tag <= G_CPU;
          end
          default: ;
        endcase

        if (!cpu_req || grant == G_CPU)
          starve <= 8'h00;
        else if (starve != STARVE_LIM)
          starve <= starve + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vdc_ram_arbiter.sv
// Scoreboard bench for vdc_ram_arbiter: stimulus pushes expected accesses and
// read returns; a monitor pops and compares whenever the DUT reports one.
module tb_vdc_ram_arbiter;
  import vdc_pkg::*;

  localparam int REF_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             ram64k;
  logic             reg_ram;
  logic             refresh_start;
  logic [REF_W-1:0] refresh_cnt;
  logic             refresh_busy;
  logic             disp_req;
  logic [15:0]      disp_addr;
  logic             disp_ack;
  logic [7:0]       disp_data;
  logic             disp_valid;
  logic             cpu_req;
  logic             cpu_we;
  logic [15:0]      cpu_addr;
  logic [7:0]       cpu_di;
  logic             cpu_ack;
  logic [7:0]       cpu_do;
  logic             cpu_valid;
  logic [15:0]      ram_addr;
  logic             ram_we;
  logic [7:0]       ram_di;
  logic [7:0]       ram_do;

  vdc_ram_arbiter #(.STARVE_MAX(8), .REF_W(REF_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ram64k        (ram64k),
    .reg_ram       (reg_ram),
    .refresh_start (refresh_start),
    .refresh_cnt   (refresh_cnt),
    .refresh_busy  (refresh_busy),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_ack      (disp_ack),
    .disp_data     (disp_data),
    .disp_valid    (disp_valid),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_di        (cpu_di),
    .cpu_ack       (cpu_ack),
    .cpu_do        (cpu_do),
    .cpu_valid     (cpu_valid),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_di        (ram_di),
    .ram_do        (ram_do)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; slots come every other clock so data settles in between.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  logic en_run;
  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      enable = en_run ? ~enable : 1'b0;
    end
  end

  typedef struct packed {
    grant_t      kind;
    logic        we;
    logic [15:0] addr;
  } acc_t;

  typedef struct packed {
    grant_t     kind;
    logic [7:0] data;
  } val_t;

  acc_t q_acc[$];
  val_t q_val[$];
  int   checks   = 0;
  int   failures = 0;
  int   we_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=nothing", name, act);
  endtask

  function automatic logic [63:0] all_outs();
    return {18'b0, refresh_busy, disp_ack, disp_data, disp_valid, cpu_ack, cpu_do,
            cpu_valid, ram_addr, ram_we, ram_di};
  endfunction

  // Monitor: one record per access slot and per returned read.
  logic slot_ref = 1'b0;
  always @(posedge clk) slot_ref <= enable && refresh_busy && !reset;

  acc_t mon_acc;
  val_t mon_val;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (ram_we) begin
        we_cnt++;
        check("we_has_cpu_ack", 64'(cpu_ack), 64'd1);
      end
      if (disp_ack && cpu_ack) check("single_ack", 64'(disp_ack & cpu_ack), 64'd0);
      if (disp_ack || cpu_ack || slot_ref) begin
        mon_acc = '{kind: disp_ack ? G_DISP : (cpu_ack ? G_CPU : G_REF), we: ram_we, addr: ram_addr};
        if (q_acc.size() == 0) unexpected("access", 64'(mon_acc));
        else check("access", 64'(mon_acc), 64'(q_acc.pop_front()));
      end
      if (disp_valid || cpu_valid) begin
        mon_val = '{kind: disp_valid ? G_DISP : G_CPU, data: disp_valid ? disp_data : cpu_do};
        if (q_val.size() == 0) unexpected("read_return", 64'(mon_val));
        else check("read_return", 64'(mon_val), 64'(q_val.pop_front()));
      end
    end
  end

  task automatic slot_wait();
    do @(negedge clk); while (!enable);
  endtask

  task automatic wait_ack(input string name, input bit is_cpu);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = is_cpu ? cpu_ack : disp_ack;
    end
    check(name, 64'(got), 64'd1);
  endtask

  task automatic disp_read(input logic [15:0] a, input logic [15:0] phys, input logic [7:0] d);
    q_acc.push_back(acc_t'{kind: G_DISP, we: 1'b0, addr: phys});
    q_val.push_back(val_t'{kind: G_DISP, data: d});
    disp_addr = a;
    disp_req  = 1'b1;
    wait_ack("disp_ack_seen", 1'b0);
    disp_req  = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [15:0] phys,
                            input logic [7:0] di, input logic [7:0] d, input bit expect_val);
    q_acc.push_back(acc_t'{kind: G_CPU, we: we, addr: phys});
    if (!we && expect_val) q_val.push_back(val_t'{kind: G_CPU, data: d});
    cpu_we   = we;
    cpu_addr = a;
    cpu_di   = di;
    cpu_req  = 1'b1;
    wait_ack("cpu_ack_seen", 1'b1);
    cpu_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int n_ack;
  int we_base;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'hA5;
    mem[16'h7EFF] = 8'hC3;

    reset = 1'b1; en_run = 1'b1; ram64k = 1'b1; reg_ram = 1'b1;
    refresh_start = 1'b0; refresh_cnt = '0;
    disp_req = 1'b0; disp_addr = 16'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_di = 8'h00;

    repeat (4) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 64'd0);

    // 1: display read, ack at first slot, data one slot later.
    slot_wait();
    q_acc.push_back(acc_t'{kind: G_DISP, we: 1'b0, addr: 16'h0100});
    q_val.push_back(val_t'{kind: G_DISP, data: 8'hA5});
    disp_addr = 16'h0100;
    disp_req  = 1'b1;
    @(negedge clk);
    check("t1_ack_slot1", 64'(disp_ack), 64'd1);
    disp_req = 1'b0;
    @(negedge clk);
    check("t1_ack_pulse", 64'(disp_ack), 64'd0);
    check("t1_no_early_valid", 64'(disp_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_slot2", {55'd0, disp_valid, disp_data}, {55'd0, 1'b1, 8'hA5});

    // 2: write then immediate read-back of the same address.
    we_base = we_cnt;
    cpu_access(1'b1, 16'h2000, 16'h2000, 8'h5A, 8'h00, 1'b0);
    cpu_access(1'b0, 16'h2000, 16'h2000, 8'h00, 8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("t2_single_write", 64'(we_cnt - we_base), 64'd1);

    // 3: continuous display fetch; CPU forced through after 8 denied slots, twice.
    for (int r = 0; r < 2; r++) begin
      slot_wait();
      for (int i = 0; i < 8; i++) begin
        q_acc.push_back(acc_t'{kind: G_DISP, we: 1'b0, addr: 16'h0100});
        q_val.push_back(val_t'{kind: G_DISP, data: 8'hA5});
      end
      q_acc.push_back(acc_t'{kind: G_CPU, we: 1'b0, addr: 16'h2000});
      q_val.push_back(val_t'{kind: G_CPU, data: 8'h5A});
      disp_addr = 16'h0100; cpu_we = 1'b0; cpu_addr = 16'h2000;
      disp_req  = 1'b1;     cpu_req = 1'b1;
      wait_ack("t3_cpu_forced", 1'b1);
      disp_req = 1'b0; cpu_req = 1'b0;
      repeat (4) @(negedge clk);
    end

    // 4: refresh burst of 5 pre-empts a waiting display; a restart mid-burst is ignored.
    slot_wait();
    refresh_cnt = 4'd5; refresh_start = 1'b1;
    for (int i = 0; i < 5; i++)
      q_acc.push_back(acc_t'{kind: G_REF, we: 1'b0, addr: 16'(i)});
    q_acc.push_back(acc_t'{kind: G_DISP, we: 1'b0, addr: 16'h0100});
    q_val.push_back(val_t'{kind: G_DISP, data: 8'hA5});
    @(negedge clk);
    check("t4_busy_rise", 64'(refresh_busy), 64'd1);
    refresh_cnt = 4'd15;
    @(negedge clk);
    refresh_start = 1'b0;
    disp_addr = 16'h0100; disp_req = 1'b1;
    wait_ack("t4_disp_after_ref", 1'b0);
    disp_req = 1'b0;
    check("t4_busy_fall", 64'(refresh_busy), 64'd0);
    repeat (4) @(negedge clk);

    // 5: 16k address shuffles.
    ram64k = 1'b1; reg_ram = 1'b0;
    disp_read(16'h3FFF, 16'h7EFF, 8'hC3);
    ram64k = 1'b0; reg_ram = 1'b1;
    cpu_access(1'b0, 16'hFFFF, 16'h7EFF, 8'h00, 8'hC3, 1'b1);
    ram64k = 1'b1; reg_ram = 1'b1;
    repeat (4) @(negedge clk);

    // 6: reset one clock after a CPU read grant drops the pending return.
    cpu_access(1'b0, 16'h0100, 16'h0100, 8'h00, 8'hA5, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("t6_no_cpu_valid", 64'(cpu_valid), 64'd0);

    en_run = 1'b0;
    repeat (2) @(negedge clk);
    disp_addr = 16'h0100; disp_req = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (disp_ack || cpu_ack) n_ack++;
      if (ram_we) n_ack++;
    end
    check("t6_no_acks_enable_low", 64'(n_ack), 64'd0);
    disp_req = 1'b0;
    en_run   = 1'b1;

    repeat (6) @(negedge clk);
    check("acc_queue_drained", 64'(q_acc.size()), 64'd0);
    check("val_queue_drained", 64'(q_val.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
